sync_debounce_edge: RTL

Downstream consumer of the two-flop synchronizer output in the iCE40UP SoM fabric. It takes an already-synchronized level and qualifies it with a programmable stability counter. It produces a debounced level plus single-cycle rise and fall pulses for control logic. Typical use is buttons, sensor strobes and slow external status lines after synchronization.

---
 rtl/sync_debounce_edge.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sync_debounce_edge.sv
// rtl/sync_debounce_edge.sv - debounce a synchronized level and emit rise/fall pulses (optional SDB_GLITCH_CNT_EN adds glitch_cnt)
module sync_debounce_edge #(
    parameter int       CNT_W      = 8,
    parameter int       STABLE_CYC = 16,
    parameter logic     RST_VAL    = 1'b0
) (
    input  logic       ck,
    input  logic       cdn,
    input  logic       d_sync,
    input  logic       en,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef SDB_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    if (STABLE_CYC < 1 || STABLE_CYC > (2 ** CNT_W) - 1) begin : g_bad_stable_cyc
        $error("sync_debounce_edge: STABLE_CYC out of range for CNT_W");
    end

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge ck) begin
        if (!cdn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        if (!en) begin
            // Bypass: follow the input directly and abandon any qualification.
            q_d     = d_sync;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (d_sync != q_q) begin
                        if (STABLE_CYC == 1) begin
                            q_d = d_sync;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (d_sync == q_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        q_d     = d_sync;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == QUAL);

`ifdef SDB_GLITCH_CNT_EN
    logic [7:0] glitch_q;
    logic       glitch_rej;

    // Only an enabled QUAL->IDLE return to q counts; en=0 aborts do not.
    assign glitch_rej = en && (state_q == QUAL) && (d_sync == q_q);

    always_ff @(posedge ck) begin
        if (!cdn) begin
            glitch_q <= 8'd0;
        end else if (glitch_rej && glitch_q != 8'hFF) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
